// File: rtl/imem_boot_loader_pkg.sv
// Shared types for the instruction-memory boot loader: FSM state encoding and stream geometry.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_boot_loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam int LEN_W      = 16;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// Latency: n/a (wiring only).
// Backpressure: byte_ready gates the byte stream; the imem write port has none.
interface imem_boot_loader_if;

    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_run;
    logic        load_err;
    logic [15:0] words_loaded;

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata, core_run, load_err, words_loaded
    );

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata, core_run, load_err, words_loaded
    );

endinterface

// File: rtl/imem_boot_loader_word_assembler.sv
// Shifts accepted bytes into a big-endian 32-bit word and pulses word_full on the 4th byte.
// Latency: word_full is combinational with the 4th shift strobe; word_dat updates on that edge.
// Backpressure: none; the caller only asserts shift_en on an accepted byte.
module boot_word_assembler
    import imem_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        clr_n,
    input  logic        shift_en,
    input  logic [7:0]  byte_dat,
    output logic [31:0] word_dat,
    output logic        word_full
);

    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (shift_en) begin
            word_d = {word_q[23:0], byte_dat};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_dat  = word_q;
    assign word_full = shift_en && (cnt_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed byte image into instruction memory, then releases the core (IMEM_BOOT_LOADER_CHECKSUM_EN adds a trailing XOR byte).
// Latency: imem_we is high the cycle after a word's 4th byte is accepted; minimum word period 5 cycles.
// Backpressure: byte_ready drops during the write cycle and permanently once done or in error.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int          MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    imem_boot_loader_if.slave bus
);

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    localparam state_t S_END = S_CHK;
`else
    localparam state_t S_END = S_DONE;
`endif

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   len_full;
    logic [31:0]        addr_q, addr_d;
    logic [15:0]        words_q, words_d;
    logic               imem_we_q, imem_we_d;
    logic               core_run_q, core_run_d;
    logic               load_err_q, load_err_d;
    logic               rdy_state;
    logic               accept;
    logic               word_full;
    logic [31:0]        word_dat;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    logic [7:0]         xor_q, xor_d;
`endif

    always_comb begin
        rdy_state = 1'b0;
        case (state_q)
            S_LEN_HI, S_LEN_LO, S_DATA: rdy_state = 1'b1;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            S_CHK:                      rdy_state = 1'b1;
`endif
            default:                    rdy_state = 1'b0;
        endcase
    end

    // Ready is held low while reset is asserted, then follows the state.
    assign bus.byte_ready = rdy_state && rst_n;
    assign accept         = bus.byte_valid && bus.byte_ready;
    assign len_full       = {len_q[LEN_W-1:8], bus.byte_data};

    boot_word_assembler u_asm (
        .clk       (clk),
        .clr_n     (rst_n),
        .shift_en  (accept && (state_q == S_DATA)),
        .byte_dat  (bus.byte_data),
        .word_dat  (word_dat),
        .word_full (word_full)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        words_d = words_q;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        xor_d   = xor_q;
`endif
        case (state_q)
            S_LEN_HI: begin
                if (accept) begin
                    len_d[LEN_W-1:8] = bus.byte_data;
                    state_d          = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_full == '0)
                        state_d = S_END;
                    else if (len_full > LEN_W'(MAX_WORDS))
                        state_d = S_ERR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                if (accept)
                    xor_d = xor_q ^ bus.byte_data;
`endif
                if (word_full)
                    state_d = S_WRITE;
            end
            S_WRITE: begin
                addr_d  = addr_q + 32'd4;
                words_d = words_q + 16'd1;
                state_d = (words_d == len_q) ? S_END : S_DATA;
            end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept)
                    state_d = (bus.byte_data == xor_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = state_q;
        endcase
        imem_we_d  = (state_d == S_WRITE);
        core_run_d = (state_d == S_DONE);
        load_err_d = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LEN_HI;
            len_q      <= '0;
            addr_q     <= BASE_ADDR;
            words_q    <= '0;
            imem_we_q  <= 1'b0;
            core_run_q <= 1'b0;
            load_err_q <= 1'b0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            xor_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            words_q    <= words_d;
            imem_we_q  <= imem_we_d;
            core_run_q <= core_run_d;
            load_err_q <= load_err_d;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

    assign bus.imem_we      = imem_we_q;
    assign bus.imem_addr    = addr_q;
    assign bus.imem_wdata   = word_dat;
    assign bus.core_run     = core_run_q;
    assign bus.load_err     = load_err_q;
    assign bus.words_loaded = words_q;

endmodule
